// File: rtl/ballot_session_ctrl_if.sv
// rtl/ballot_session_ctrl_if.sv - officer/voter/counter signal bundle for the ballot session controller
interface ballot_session_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             issue;
  logic             close_poll;
  logic [2:0]       btn;
  logic [2:0]       vote_inc;
  logic             ready_led;
  logic             ack_led;
  logic             timeout;
  logic             closed;
  logic             full;
  logic [CNT_W-1:0] voter_count;

  modport master (
    output issue, close_poll, btn,
    input  vote_inc, ready_led, ack_led, timeout, closed, full, voter_count
  );

  modport slave (
    input  issue, close_poll, btn,
    output vote_inc, ready_led, ack_led, timeout, closed, full, voter_count
  );
endinterface

// File: rtl/ballot_session_ctrl.sv
// rtl/ballot_session_ctrl.sv - one-voter-one-vote session sequencer driving the tally increment strobes
module ballot_session_ctrl #(
  parameter int HOLD_CYCLES    = 3000000,
  parameter int ACK_CYCLES     = 1000000,
  parameter int TIMEOUT_CYCLES = 30000000,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ballot_session_ctrl_if.slave bus
);

  localparam int HW   = $clog2(HOLD_CYCLES) + 1;
  localparam int TMAX = (TIMEOUT_CYCLES > ACK_CYCLES) ? TIMEOUT_CYCLES : ACK_CYCLES;
  localparam int CW   = $clog2(TMAX) + 1;

  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    ACK_LAST  = CW'(ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARMED, ACK, WAIT_REL, CLOSED} state_t;

  state_t           state_q, state_d;
  logic             rel_q, rel_d;        // all buttons seen low since arming
  logic [2:0]       track_q, track_d;    // button currently being timed
  logic [HW-1:0]    hold_q, hold_d;      // consecutive samples of the tracked button
  logic [CW-1:0]    cnt_q, cnt_d;        // ARMED age, reused as ACK length
  logic [2:0]       vote_q, vote_d;
  logic             tmo_q, tmo_d;
  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic             closed_q, closed_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             one_hot;
  logic             commit;

  assign one_hot = (bus.btn == 3'b001) || (bus.btn == 3'b010) || (bus.btn == 3'b100);

  // State and registered outputs; reset drops everything, including a pending strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rel_q    <= 1'b0;
      track_q  <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      vote_q   <= '0;
      tmo_q    <= 1'b0;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      closed_q <= 1'b0;
      full_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rel_q    <= rel_d;
      track_q  <= track_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      vote_q   <= vote_d;
      tmo_q    <= tmo_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      closed_q <= closed_d;
      full_q   <= full_d;
      count_q  <= count_d;
    end
  end

  // Next state, hold qualification, timeout and the one-shot commit
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    track_d = track_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    vote_d  = '0;
    tmo_d   = 1'b0;
    count_d = count_q;
    commit  = 1'b0;

    case (state_q)
      IDLE: begin
        rel_d   = 1'b0;
        track_d = '0;
        hold_d  = '0;
        cnt_d   = '0;
        if (bus.close_poll) begin
          state_d = CLOSED;
        end else if (bus.issue && !full_q) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.btn == 3'b000) begin
          rel_d = 1'b1;
        end
        // The current sample counts toward the hold, so a fresh press starts at 1
        if (!rel_q || !one_hot) begin
          hold_d  = '0;
          track_d = '0;
        end else if (bus.btn != track_q) begin
          hold_d  = HW'(1);
          track_d = bus.btn;
        end else if (hold_q == HOLD_LAST) begin
          commit = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
        // Commit outranks an expiry landing on the same cycle
        if (commit) begin
          vote_d  = track_q;
          count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
          cnt_d   = '0;
          state_d = ACK;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ACK_LAST) begin
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (bus.btn == 3'b000) begin
          state_d = IDLE;
        end
      end
      CLOSED: begin
        state_d = CLOSED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d  = (state_d == ARMED);
    ack_d    = (state_d == ACK);
    closed_d = (state_d == CLOSED);
    full_d   = (count_d == COUNT_MAX);
  end

  assign bus.vote_inc    = vote_q;
  assign bus.ready_led   = ready_q;
  assign bus.ack_led     = ack_q;
  assign bus.timeout     = tmo_q;
  assign bus.closed      = closed_q;
  assign bus.full        = full_q;
  assign bus.voter_count = count_q;

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// tb/tb_ballot_session_ctrl.sv - directed bench with a behavioural session model for ballot_session_ctrl
module tb_ballot_session_ctrl;
  localparam int HOLD = 4;
  localparam int ACKC = 3;
  localparam int TMO  = 20;
  localparam int CW   = 2;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ballot_session_ctrl_if #(.CNT_W(CW)) bus ();

  ballot_session_ctrl #(
    .HOLD_CYCLES(HOLD), .ACK_CYCLES(ACKC), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: session described by mode, ballot age, run length of a single pressed button
  localparam int M_IDLE = 0, M_ARMED = 1, M_ACK = 2, M_WREL = 3, M_CLOSED = 4;
  int         mode = M_IDLE;
  int         age = 0, run_len = 0, ack_left = 0, count = 0;
  logic [2:0] run_btn = 3'b000;
  bit         released = 0;
  bit         started = 0;
  logic [2:0] e_vote = 3'b000;
  logic       e_tmo = 1'b0, e_ready = 1'b0, e_ack = 1'b0, e_closed = 1'b0, e_full = 1'b0;

  always @(posedge clk) begin
    started = 1;
    e_vote  = 3'b000;
    e_tmo   = 1'b0;
    if (rst) begin
      mode = M_IDLE; count = 0; age = 0; run_len = 0; run_btn = 3'b000; released = 0; ack_left = 0;
    end else begin
      case (mode)
        M_IDLE: begin
          if (bus.close_poll) mode = M_CLOSED;
          else if (bus.issue && count < MAXC) begin
            mode = M_ARMED; age = 0; run_len = 0; run_btn = 3'b000; released = 0;
          end
        end
        M_ARMED: begin
          age++;
          if ($countones(bus.btn) == 1 && released) begin
            if (bus.btn == run_btn) run_len++;
            else begin run_btn = bus.btn; run_len = 1; end
          end else begin
            run_len = 0; run_btn = 3'b000;
          end
          if (bus.btn == 3'b000) released = 1;
          if (run_len == HOLD) begin
            e_vote = run_btn;
            if (count < MAXC) count++;
            mode = M_ACK; ack_left = ACKC;
          end else if (age == TMO) begin
            e_tmo = 1'b1; mode = M_IDLE;
          end
        end
        M_ACK: begin
          ack_left--;
          if (ack_left == 0) mode = M_WREL;
        end
        M_WREL: if (bus.btn == 3'b000) mode = M_IDLE;
        default: mode = M_CLOSED;
      endcase
    end
    e_ready  = (mode == M_ARMED);
    e_ack    = (mode == M_ACK);
    e_closed = (mode == M_CLOSED);
    e_full   = (count == MAXC);
  end

  // Event tallies used by the hand-computed scenario checks
  int         v_pulses = 0, ack_cyc = 0, tmo_pulses = 0;
  logic [2:0] last_vote = 3'b000;

  always @(negedge clk) begin
    if (started) begin
      chk("vote_inc", 32'(bus.vote_inc), 32'(e_vote));
      chk("ready_led", 32'(bus.ready_led), 32'(e_ready));
      chk("ack_led", 32'(bus.ack_led), 32'(e_ack));
      chk("timeout", 32'(bus.timeout), 32'(e_tmo));
      chk("closed", 32'(bus.closed), 32'(e_closed));
      chk("full", 32'(bus.full), 32'(e_full));
      chk("voter_count", 32'(bus.voter_count), 32'(count));
      if (bus.vote_inc != 3'b000) begin v_pulses++; last_vote = bus.vote_inc; end
      if (bus.ack_led) ack_cyc++;
      if (bus.timeout) tmo_pulses++;
    end
  end

  int s_v, s_a, s_t;
  task automatic snap();
    s_v = v_pulses; s_a = ack_cyc; s_t = tmo_pulses;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] b, input int n);
    bus.btn = b;
    repeat (n) step();
  endtask

  // Issue for one cycle, then give the ballot one all-released sample
  task automatic arm();
    bus.issue = 1'b1;
    step();
    bus.issue = 1'b0;
    bus.btn = 3'b000;
    step();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_vote"}, 32'(bus.vote_inc), 32'd0);
    chk({tag, "_ready"}, 32'(bus.ready_led), 32'd0);
    chk({tag, "_ack"}, 32'(bus.ack_led), 32'd0);
    chk({tag, "_tmo"}, 32'(bus.timeout), 32'd0);
    chk({tag, "_closed"}, 32'(bus.closed), 32'd0);
    chk({tag, "_full"}, 32'(bus.full), 32'd0);
    chk({tag, "_count"}, 32'(bus.voter_count), 32'd0);
  endtask

  initial begin
    bus.issue = 1'b0; bus.close_poll = 1'b0; bus.btn = 3'b000;
    rst = 1'b1;
    step(); step();
    all_zero("reset");
    rst = 1'b0;
    step();

    // Single held press, held past the commit, then released
    snap(); arm(); hold(3'b001, 4);
    chk("s1_vote_now", 32'(bus.vote_inc), 32'd1);
    chk("s1_ack_now", 32'(bus.ack_led), 32'd1);
    hold(3'b001, 8); hold(3'b000, 3);
    chk("s1_pulses", 32'(v_pulses - s_v), 32'd1);
    chk("s1_last", 32'(last_vote), 32'd1);
    chk("s1_count", 32'(bus.voter_count), 32'd1);
    chk("s1_ack_cycles", 32'(ack_cyc - s_a), 32'd3);

    // Switching buttons restarts the hold
    snap(); arm(); hold(3'b010, 3); hold(3'b100, 4); hold(3'b100, 4); hold(3'b000, 3);
    chk("s2_pulses", 32'(v_pulses - s_v), 32'd1);
    chk("s2_last", 32'(last_vote), 32'd4);
    chk("s2_count", 32'(bus.voter_count), 32'd2);

    // Button already down at arming never votes until released
    snap(); bus.btn = 3'b100; bus.issue = 1'b1; step(); bus.issue = 1'b0;
    hold(3'b100, 10);
    chk("s4_no_vote", 32'(v_pulses - s_v), 32'd0);
    hold(3'b000, 1); hold(3'b100, 4); hold(3'b000, 5);
    chk("s4_pulses", 32'(v_pulses - s_v), 32'd1);
    chk("s4_last", 32'(last_vote), 32'd4);
    chk("s4_count", 32'(bus.voter_count), 32'd3);
    chk("s4_full", 32'(bus.full), 32'd1);

    // Saturated count: issue is ignored
    bus.issue = 1'b1; step(); step(); bus.issue = 1'b0; step();
    chk("full_no_arm", 32'(bus.ready_led), 32'd0);
    chk("full_count", 32'(bus.voter_count), 32'd3);

    rst = 1'b1; step(); rst = 1'b0; step();
    chk("rst_count", 32'(bus.voter_count), 32'd0);

    // Two buttons together never qualify
    snap(); arm(); hold(3'b011, 10);
    chk("s3_no_vote", 32'(v_pulses - s_v), 32'd0);
    hold(3'b001, 4); hold(3'b000, 5);
    chk("s3_pulses", 32'(v_pulses - s_v), 32'd1);
    chk("s3_last", 32'(last_vote), 32'd1);
    chk("s3_count", 32'(bus.voter_count), 32'd1);

    // Reset in the middle of a hold
    snap(); arm(); hold(3'b010, 3);
    rst = 1'b1; step();
    all_zero("midhold_rst");
    chk("midhold_pulses", 32'(v_pulses - s_v), 32'd0);
    bus.btn = 3'b000; rst = 1'b0; step();

    // Unattended ballot expires
    snap(); arm(); hold(3'b000, 19);
    chk("s5_tmo_now", 32'(bus.timeout), 32'd1);
    chk("s5_ready_now", 32'(bus.ready_led), 32'd0);
    hold(3'b000, 3);
    chk("s5_tmo_pulses", 32'(tmo_pulses - s_t), 32'd1);
    chk("s5_no_vote", 32'(v_pulses - s_v), 32'd0);
    chk("s5_count", 32'(bus.voter_count), 32'd0);

    // close_poll beats issue; closed poll ignores everything
    bus.issue = 1'b1; bus.close_poll = 1'b1; step();
    bus.issue = 1'b0; bus.close_poll = 1'b0; step();
    chk("close_closed", 32'(bus.closed), 32'd1);
    chk("close_ready", 32'(bus.ready_led), 32'd0);
    snap(); bus.issue = 1'b1; step(); bus.issue = 1'b0;
    hold(3'b000, 1); hold(3'b001, 6); hold(3'b000, 2);
    chk("closed_no_vote", 32'(v_pulses - s_v), 32'd0);
    chk("closed_stays", 32'(bus.closed), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
